// File: rtl/wb_txfifo.sv
// Wishbone-to-byte-stream transmit FIFO: Wishbone writes push bytes, a valid/ready stream drains them.
// Optional feature macro: WB_TXFIFO_BACKPRESSURE_EN (stall writes while full instead of dropping).
module wb_txfifo #(
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  output logic                     o_wb_stall,
  output logic                     o_wb_ack,
  input  logic                     i_wb_we,
  input  logic [31:0]              i_wb_data,
  output logic [31:0]              o_wb_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [7:0]               o_tx_data,
  output logic [FIFO_ADDR_WIDTH:0] o_fifo_count,
  output logic                     o_fifo_empty,
  output logic                     o_fifo_full,
  output logic                     o_fifo_half_full,
  output logic                     o_fifo_overflow
);

  localparam int LP_DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0]   LP_FULL_CNT = (FIFO_ADDR_WIDTH+1)'(LP_DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0]   LP_HALF_CNT = (FIFO_ADDR_WIDTH+1)'(LP_DEPTH / 2);
  localparam logic [FIFO_ADDR_WIDTH:0]   LP_CNT_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] LP_PTR_ONE  = FIFO_ADDR_WIDTH'(1);

  logic [7:0]                 r_mem [LP_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   r_count;
  logic                       r_pend;
  logic                       r_ack;
  logic [31:0]                r_rdata;

  logic        w_accept;
  logic        w_push_req;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_full     = (r_count == LP_FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_accept   = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign w_push_req = w_accept && i_wb_we;
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = o_tx_valid && i_tx_ready;
  assign w_unused   = &{1'b0, i_wb_data[31:8]};

  assign o_fifo_count     = r_count;
  assign o_fifo_empty     = w_empty;
  assign o_fifo_full      = w_full;
  assign o_fifo_half_full = (r_count >= LP_HALF_CNT);
  assign o_tx_valid       = !w_empty;
  assign o_tx_data        = r_mem[r_rd_ptr];
  assign o_wb_ack         = r_ack;
  assign o_wb_data        = r_rdata;

`ifdef WB_TXFIFO_BACKPRESSURE_EN
  assign o_wb_stall      = i_wb_we && w_full;
  assign o_fifo_overflow = 1'b0;
`else
  logic r_overflow;
  assign o_wb_stall      = 1'b0;
  assign o_fifo_overflow = r_overflow;
`endif

  // Status word snapshot source for register reads.
  always_comb begin
    w_status                    = 32'h0000_0000;
    w_status[FIFO_ADDR_WIDTH:0] = r_count;
    w_status[16]                = w_empty;
    w_status[17]                = w_full;
    w_status[18]                = o_fifo_half_full;
  end

  // Byte storage; intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wb_data[7:0];
    end
  end

  // Pointers, occupancy, and the two-stage ack pipeline (ack dropped if the cycle is abandoned).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pend     <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= 32'h0000_0000;
`ifndef WB_TXFIFO_BACKPRESSURE_EN
      r_overflow <= 1'b0;
`endif
    end else begin
      r_pend <= w_accept;
      r_ack  <= r_pend && i_wb_cyc;
      if (w_accept && !i_wb_we) begin
        r_rdata <= w_status;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
`ifndef WB_TXFIFO_BACKPRESSURE_EN
      r_overflow <= w_push_req && w_full;
`endif
    end
  end

endmodule

// File: doc/wb_txfifo.md
# wb_txfifo

Wishbone-to-byte-stream transmit FIFO: the transmit counterpart of `wb_rxfifo`. Pipelined Wishbone writes push bytes into an internal FIFO. The FIFO drains through a valid/ready byte stream toward the transmit datapath (UART/serialiser side). Wishbone reads return FIFO status so firmware can pace writes.

## Interface
- `FIFO_ADDR_WIDTH`, 3, log2 of FIFO depth; depth = 2^FIFO_ADDR_WIDTH bytes; legal range 1..15.

Ports:
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_wb_cyc`  in  1  Wishbone cycle.
- `i_wb_stb`  in  1  Wishbone strobe.
- `o_wb_stall`  out  1  Wishbone stall.
- `o_wb_ack`  out  1  Wishbone acknowledge.
- `i_wb_we`  in  1  write enable.
- `i_wb_data`  in  32  write data; only [7:0] is used.
- `o_wb_data`  out  32  read data (status word).
- `o_tx_valid`  out  1  stream byte available.
- `i_tx_ready`  in  1  stream sink ready.
- `o_tx_data`  out  8  stream byte.
- `o_fifo_count`  out  FIFO_ADDR_WIDTH+1  bytes stored.
- `o_fifo_empty`  out  1  count == 0.
- `o_fifo_full`  out  1  count == depth.
- `o_fifo_half_full`  out  1  count >= depth/2.
- `o_fifo_overflow`  out  1  one-cycle pulse: a write byte was dropped.

## Operation
- Request accepted when `i_wb_cyc && i_wb_stb && !o_wb_stall`.
- Accepted write: pushes `i_wb_data[7:0]` at the write pointer, unless the FIFO is full.
- Write while full: the byte is dropped. `o_fifo_overflow` pulses for the following cycle. The write is still acked.
- Accepted read: `o_wb_data` is registered as follows:
  - [FIFO_ADDR_WIDTH:0] = count
  - [16] = empty
  - [17] = full
  - [18] = half_full
  - all other bits 0
- Accepted read has no side effects on the FIFO.
- `o_wb_data` holds its value until the next accepted read.
- Pop: occurs when `o_tx_valid && i_tx_ready`.
  - `o_tx_valid` = !empty.
  - `o_tx_data` = memory at the read pointer. It is stable while valid and no pop occurs.
- Pointers are FIFO_ADDR_WIDTH bits and wrap modulo depth. The count is tracked separately.
- Same-cycle push and pop: count unchanged, both pointers advance.
- Full check uses the pre-edge count. A write while full is dropped even if a pop happens in the same cycle.
- Status outputs (`o_fifo_empty`, `o_fifo_full`, `o_fifo_half_full`) are derived combinationally from the registered count.
- Reset:
  - Pointers, count, `o_wb_ack`, `o_wb_data`, and `o_fifo_overflow` are cleared to 0.
  - Therefore `o_fifo_empty`=1, `o_tx_valid`=0, `o_fifo_full`=0, `o_fifo_half_full`=0.
  - Memory contents are not reset.
- Reset asserted mid-transaction: a pending ack is discarded and FIFO contents are lost.

## Timing
- Request accepted at edge N → `o_wb_ack` high for exactly one cycle after edge N+1 (registered, one per request).
- Back-to-back requests on consecutive cycles are supported, giving back-to-back acks.
- If `i_wb_cyc` is low at edge N+1, the ack for that request is suppressed.
- Write accepted at edge N:
  - `o_fifo_count` and `o_tx_valid` reflect the push after edge N.
  - The byte is poppable at edge N+1 at the earliest.
- Read accepted at edge N: `o_wb_data` shows the status sampled before edge N, valid together with the ack.
- `o_wb_stall` is 0 unless `WB_TXFIFO_BACKPRESSURE_EN` is defined.
- `o_tx_valid` never deasserts without a pop, except by reset.

## Configuration
- `WB_TXFIFO_BACKPRESSURE_EN` defined:
  - `o_wb_stall` = `i_wb_we && o_fifo_full` (combinational). Writes wait instead of dropping.
  - Reads are never stalled.
  - `o_fifo_overflow` is tied to 0.
- `WB_TXFIFO_BACKPRESSURE_EN` undefined: drop-and-flag behaviour as described in Operation. `o_wb_stall` is tied to 0.

## Test plan
All scenarios use FIFO_ADDR_WIDTH=3 (depth 8).
- Reset: assert `i_rst` with a running clock → count=0, empty=1, `o_tx_valid`=0, `o_wb_ack`=0, `o_fifo_overflow`=0. Release → no ack without a request.
- Single write: write 0x1234_56A5 with `i_tx_ready`=0 → one ack, count=1, `o_tx_valid`=1, `o_tx_data`=0xA5. Raise ready for one cycle → byte popped, empty=1.
- Fill and overflow (macro undefined), `i_tx_ready`=0:
  - Writes 0..9 → half_full rises at count=4, full at count=8.
  - Writes 8 and 9 are acked, each followed by a one-cycle overflow pulse.
  - Draining yields 0x00..0x07 in order.
- Backpressure (macro defined), `i_tx_ready`=0:
  - 9th write is stalled, ack withheld.
  - Pulse ready once → stall drops, write accepted, count=8, overflow never asserted.
- Wrap and simultaneous push/pop, `i_tx_ready`=1 continuously: 20 consecutive writes of 0..19 → stream emits 0..19 in order, count never exceeds 1, no overflow.
- Status read: after 5 writes with ready=0, read → `o_wb_data`=0x0000_0005 with half_full bit 18 set, i.e. 0x0004_0005. Dropping `i_wb_cyc` before the ack cycle → no ack.
